// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared en command encodings and stopwatch FSM states
package stopwatch_pkg;

    localparam logic [1:0] EN_CLEAR = 2'b00;
    localparam logic [1:0] EN_RUN   = 2'b01;
    localparam logic [1:0] EN_HOLD  = 2'b10;

    // State codes match the en codes so the decode is a straight mapping
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    function automatic logic [1:0] state_to_en(input state_t s);
        case (s)
            ST_RUN:  return EN_RUN;
            ST_HOLD: return EN_HOLD;
            default: return EN_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, level debouncer and rising-edge press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             w_accept;

    // A new level is taken once it has differed from the accepted one long enough
    assign w_accept = (r_sync2 != r_level) && (r_cnt == LP_LAST);
    assign o_press  = r_press;

    // Bring the raw button into the clock domain before anything looks at it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Count how long the synchronized level has disagreed with the accepted level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync2 == r_level) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // One-cycle pulse only when the accepted level goes 0->1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_press <= 1'b0;
        end else begin
            r_press <= w_accept && r_sync2;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - start/stop/clear stopwatch command FSM driving the tick counter
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       hard_reset,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic [1:0] en,
    output logic       running
);

    logic       w_ss_press;
    logic       w_clr_press;
    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_en;
    logic       r_running;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_start_stop (
        .clk    (clk),
        .rst    (hard_reset),
        .i_btn  (btn_start_stop),
        .o_press(w_ss_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_clear (
        .clk    (clk),
        .rst    (hard_reset),
        .i_btn  (btn_clear),
        .o_press(w_clr_press)
    );

    assign en      = r_en;
    assign running = r_running;

    // Next state; in HOLD clear takes priority over start_stop, any bad code goes IDLE
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: w_next = w_ss_press ? ST_RUN : ST_IDLE;
            ST_RUN:  w_next = w_ss_press ? ST_HOLD : ST_RUN;
            ST_HOLD: begin
                if (w_clr_press) begin
                    w_next = ST_IDLE;
                end else if (w_ss_press) begin
                    w_next = ST_RUN;
                end else begin
                    w_next = ST_HOLD;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State plus registered en/running decoded from the state being entered
    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            r_state   <= ST_IDLE;
            r_en      <= EN_CLEAR;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_en      <= state_to_en(w_next);
            r_running <= (w_next == ST_RUN);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic       clk;
    logic       hard_reset;
    logic       btn_start_stop;
    logic       btn_clear;
    logic [1:0] en;
    logic       running;

    int checks;
    int failures;
    int n_trans;
    int n_run;
    int base_trans;
    int base_run;
    logic [1:0] prev_en;

    typedef struct {
        logic       ss;
        logic       clr;
        logic [1:0] exp_en;
    } vec_t;

    vec_t vecs [8];

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk           (clk),
        .hard_reset    (hard_reset),
        .btn_start_stop(btn_start_stop),
        .btn_clear     (btn_clear),
        .en            (en),
        .running       (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_en(input string name, input logic [1:0] exp_en);
        checks++;
        if (en !== exp_en || running !== (exp_en == EN_RUN)) begin
            failures++;
            $display("FAIL %s: en=%b running=%b, required en=%b running=%b",
                     name, en, running, exp_en, (exp_en == EN_RUN));
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // One clock, sampled 1 time unit after the edge; tracks en transitions
    task automatic tick();
        @(posedge clk);
        #1;
        if (en !== prev_en) begin
            n_trans++;
            if (en === EN_RUN) n_run++;
        end
        prev_en = en;
        checks++;
        if (en === 2'b11 || running !== (en === EN_RUN)) begin
            failures++;
            $display("FAIL invariant: en=%b running=%b", en, running);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic press(input logic ss, input logic clr);
        btn_start_stop = ss;
        btn_clear      = clr;
        ticks(10);
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        ticks(10);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        n_trans        = 0;
        n_run          = 0;
        prev_en        = 2'b00;
        hard_reset     = 1'b1;
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;

        // Starting in RUN
        vecs[0] = '{ss: 1'b0, clr: 1'b1, exp_en: EN_RUN};
        vecs[1] = '{ss: 1'b1, clr: 1'b0, exp_en: EN_HOLD};
        vecs[2] = '{ss: 1'b0, clr: 1'b1, exp_en: EN_CLEAR};
        vecs[3] = '{ss: 1'b0, clr: 1'b1, exp_en: EN_CLEAR};
        vecs[4] = '{ss: 1'b1, clr: 1'b1, exp_en: EN_RUN};
        vecs[5] = '{ss: 1'b1, clr: 1'b1, exp_en: EN_HOLD};
        vecs[6] = '{ss: 1'b1, clr: 1'b0, exp_en: EN_RUN};
        vecs[7] = '{ss: 1'b1, clr: 1'b0, exp_en: EN_HOLD};

        ticks(3);
        check_en("reset_state", EN_CLEAR);
        hard_reset = 1'b0;

        // First press: en must move on the 7th edge after the raw rise
        base_trans     = n_trans;
        btn_start_stop = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6) check_en("latency_before", EN_CLEAR);
            if (i == 7) check_en("latency_at", EN_RUN);
        end
        btn_start_stop = 1'b0;
        ticks(10);
        check_en("first_press_run", EN_RUN);
        check_int("first_press_trans", n_trans - base_trans, 1);

        // Bounce shorter than the debounce window
        base_trans = n_trans;
        for (int i = 0; i < 20; i++) begin
            btn_start_stop = ((i / 2) % 2) == 0;
            tick();
        end
        btn_start_stop = 1'b0;
        ticks(10);
        check_en("bounce_stays_run", EN_RUN);
        check_int("bounce_trans", n_trans - base_trans, 0);

        for (int v = 0; v < 8; v++) begin
            press(vecs[v].ss, vecs[v].clr);
            checks++;
            if (en !== vecs[v].exp_en || running !== (vecs[v].exp_en == EN_RUN)) begin
                failures++;
                $display("FAIL vec%0d: en=%b running=%b, required en=%b", v, en, running, vecs[v].exp_en);
            end
        end

        // From HOLD both buttons together: clear wins, never passes through RUN
        base_trans = n_trans;
        base_run   = n_run;
        press(1'b1, 1'b1);
        check_en("both_from_hold", EN_CLEAR);
        check_int("both_from_hold_trans", n_trans - base_trans, 1);
        check_int("both_from_hold_run", n_run - base_run, 0);

        press(1'b1, 1'b0);
        check_en("back_to_run", EN_RUN);

        // Asynchronous reset mid-run with start_stop held
        btn_start_stop = 1'b1;
        @(posedge clk);
        #3;
        hard_reset = 1'b1;
        #1;
        check_en("async_reset_immediate", EN_CLEAR);
        repeat (3) @(posedge clk);
        #3;
        hard_reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6) check_en("post_reset_before", EN_CLEAR);
            if (i == 7) check_en("post_reset_at", EN_RUN);
        end
        btn_start_stop = 1'b0;
        ticks(10);
        check_en("post_reset_run", EN_RUN);

        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check_en("back_to_idle", EN_CLEAR);

        // Long hold gives exactly one press
        base_trans     = n_trans;
        btn_start_stop = 1'b1;
        ticks(100);
        btn_start_stop = 1'b0;
        ticks(10);
        check_en("long_hold_run", EN_RUN);
        check_int("long_hold_trans", n_trans - base_trans, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
